snoop_responder: RTL

SNOOP_RESPONDER -- requirements
Module: snoop_responder

---
 rtl/snoop_responder.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/snoop_responder.sv
// Snoop responder: looks up a snooped bus address in the cache tag store,
// writes back modified lines when required, downgrades or invalidates the
// hit way, and reports NOHIT / HIT / HITM for every accepted snoop.
//
// Ports:
//   clk, rst          clock (rising edge), async active-low reset
//   snp_*             snooped operation in (valid/ready, op, addr)
//   tag_rd_*          tag-store read: strobe + index out, tags/MESI back
//                     one cycle after the strobe
//   tag_wr_*          MESI update strobe, index, way, new state
//   wb_*              modified-line writeback request (valid/ready, addr)
//   rsp_*             one-cycle snoop result strobe and result code
//   snp_count         saturating count of accepted snoops
//   hitm_count        saturating count of HITM responses
module snoop_responder #(
    parameter int WAYS    = 8,
    parameter int TAG_W   = 12,
    parameter int INDEX_W = 14,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    snp_valid,
    output logic                    snp_ready,
    input  logic [1:0]              snp_op,
    input  logic [31:0]             snp_addr,
    output logic                    tag_rd_en,
    output logic [INDEX_W-1:0]      tag_rd_index,
    input  logic [WAYS*TAG_W-1:0]   tag_rd_tags,
    input  logic [WAYS*2-1:0]       tag_rd_mesi,
    output logic                    tag_wr_en,
    output logic [INDEX_W-1:0]      tag_wr_index,
    output logic [$clog2(WAYS)-1:0] tag_wr_way,
    output logic [1:0]              tag_wr_mesi,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [31:0]             wb_addr,
    output logic                    rsp_valid,
    output logic [1:0]              rsp_result,
    output logic [CNT_W-1:0]        snp_count,
    output logic [CNT_W-1:0]        hitm_count
);

    localparam int WAY_W  = $clog2(WAYS);
    // Line address is addr[31:6]; tag and index are both carved from it.
    localparam int LINE_W = 26;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_INVAL = 2'd2;
    localparam logic [1:0] OP_RWIM  = 2'd3;

    localparam logic [1:0] MESI_I = 2'd0;
    localparam logic [1:0] MESI_S = 2'd1;
    localparam logic [1:0] MESI_M = 2'd3;

    localparam logic [1:0] RES_NOHIT = 2'd0;
    localparam logic [1:0] RES_HIT   = 2'd1;
    localparam logic [1:0] RES_HITM  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        WRITEBACK,
        UPDATE,
        RESPOND
    } state_t;

    state_t state;
    state_t state_nx;

    logic [1:0]        op_q;
    logic [LINE_W-1:0] line_q;
    logic [WAY_W-1:0]  way_q;
    logic [1:0]        mesi_q;

    logic              accept;
    logic [TAG_W-1:0]  tag_q;
    logic [INDEX_W-1:0] index_q;

    logic              hit_c;
    logic [WAY_W-1:0]  hit_way_c;
    logic [1:0]        hit_mesi_c;

    logic [WAY_W-1:0]  way_nx;
    logic [1:0]        res_nx;
    logic [1:0]        new_mesi;

    // The byte offset never matters to a line-granular snoop.
    logic [5:0]        unused_offset;

    assign unused_offset = snp_addr[5:0];

    assign tag_q   = line_q[LINE_W-1 -: TAG_W];
    assign index_q = line_q[INDEX_W-1:0];

    assign snp_ready = (state == IDLE) && rst;
    assign accept    = snp_valid && snp_ready;

    function automatic logic [1:0] snoop_result(
        input logic       hit,
        input logic [1:0] op,
        input logic [1:0] mesi
    );
        if (!hit || op == OP_WRITE) begin
            return RES_NOHIT;
        end
        // INVALIDATE reports a plain HIT even on a modified line.
        if (mesi == MESI_M && op != OP_INVAL) begin
            return RES_HITM;
        end
        return RES_HIT;
    endfunction

    // Way compare; scanning from the top down lets the lowest matching
    // way overwrite any higher one.
    always_comb begin
        hit_c      = 1'b0;
        hit_way_c  = '0;
        hit_mesi_c = MESI_I;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (tag_rd_tags[w*TAG_W +: TAG_W] == tag_q &&
                tag_rd_mesi[w*2 +: 2] != MESI_I) begin
                hit_c      = 1'b1;
                hit_way_c  = w[WAY_W-1:0];
                hit_mesi_c = tag_rd_mesi[w*2 +: 2];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = LOOKUP;
                end
            end
            LOOKUP: begin
                state_nx = COMPARE;
            end
            COMPARE: begin
                if (!hit_c || op_q == OP_WRITE) begin
                    state_nx = RESPOND;
                end else if (hit_mesi_c == MESI_M &&
                             (op_q == OP_READ || op_q == OP_RWIM)) begin
                    state_nx = WRITEBACK;
                end else begin
                    state_nx = UPDATE;
                end
            end
            WRITEBACK: begin
                if (wb_ready) begin
                    state_nx = UPDATE;
                end
            end
            UPDATE: begin
                state_nx = RESPOND;
            end
            RESPOND: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Hit way/state are registered in COMPARE, but the edge leaving
    // COMPARE must already use the freshly compared values.
    always_comb begin
        way_nx   = way_q;
        res_nx   = snoop_result(1'b1, op_q, mesi_q);
        new_mesi = (op_q == OP_READ) ? MESI_S : MESI_I;
        if (state == COMPARE) begin
            way_nx = hit_way_c;
            res_nx = snoop_result(hit_c, op_q, hit_mesi_c);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            op_q         <= OP_READ;
            line_q       <= '0;
            way_q        <= '0;
            mesi_q       <= MESI_I;
            tag_rd_en    <= 1'b0;
            tag_rd_index <= '0;
            tag_wr_en    <= 1'b0;
            tag_wr_index <= '0;
            tag_wr_way   <= '0;
            tag_wr_mesi  <= MESI_I;
            wb_valid     <= 1'b0;
            wb_addr      <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= RES_NOHIT;
            snp_count    <= '0;
            hitm_count   <= '0;
        end else begin
            state <= state_nx;

            if (accept) begin
                op_q         <= snp_op;
                line_q       <= snp_addr[31:6];
                tag_rd_index <= snp_addr[6 +: INDEX_W];
                if (snp_count != CNT_MAX) begin
                    snp_count <= snp_count + CNT_W'(1);
                end
            end

            if (state == COMPARE) begin
                way_q  <= hit_way_c;
                mesi_q <= hit_mesi_c;
            end

            // Strobes are registered from the next state so that each one
            // is high exactly while the FSM sits in its owning state.
            tag_rd_en <= (state_nx == LOOKUP);
            wb_valid  <= (state_nx == WRITEBACK);
            tag_wr_en <= (state_nx == UPDATE);
            rsp_valid <= (state_nx == RESPOND);

            if (state == COMPARE && state_nx == WRITEBACK) begin
                wb_addr <= {line_q, 6'b0};
            end

            if (state != UPDATE && state_nx == UPDATE) begin
                tag_wr_index <= index_q;
                tag_wr_way   <= way_nx;
                tag_wr_mesi  <= new_mesi;
            end

            if (state_nx == RESPOND) begin
                rsp_result <= res_nx;
                if (res_nx == RES_HITM && hitm_count != CNT_MAX) begin
                    hitm_count <= hitm_count + CNT_W'(1);
                end
            end else begin
                rsp_result <= RES_NOHIT;
            end
        end
    end

endmodule
